can_bit_destuffer: RTL and testbench



---
 rtl/can_pkg.sv | 32 +++
 rtl/can_bit_destuffer.sv | 119 +++++++++++
 tb/tb_can_bit_destuffer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/can_pkg.sv
// Shared CAN receive-path constants and the stuffing-mode classification
// used by the bit destuffer.
package can_pkg;

  localparam int unsigned CAN_RUN_LEN      = 5;
  localparam int unsigned CAN_FD_FIXED_LEN = 4;
  localparam int unsigned CAN_STUFF_CNT_W  = 3;
  localparam int unsigned CAN_RUN_W        = 3;

  localparam logic DOMINANT  = 1'b0;
  localparam logic RECESSIVE = 1'b1;

  typedef enum logic [1:0] {
    STUFF_OFF   = 2'd0,
    STUFF_DYN   = 2'd1,
    STUFF_FIXED = 2'd2
  } stuff_mode_e;

  // Fixed stuffing only applies while destuffing is enabled.
  function automatic stuff_mode_e stuff_mode(input logic en, input logic fixed);
    stuff_mode_e m;
    if (!en) begin
      m = STUFF_OFF;
    end else if (fixed) begin
      m = STUFF_FIXED;
    end else begin
      m = STUFF_DYN;
    end
    return m;
  endfunction

endpackage

// File: rtl/can_bit_destuffer.sv
// CAN receive bit destuffer: removes dynamic (run-length) and FD fixed stuff
// bits, flags stuff errors and keeps the modulo dynamic stuff count.
module can_bit_destuffer
  import can_pkg::*;
#(
  parameter int unsigned RUN_LEN   = CAN_RUN_LEN,
  parameter int unsigned FIXED_LEN = CAN_FD_FIXED_LEN,
  parameter int unsigned RUN_W     = CAN_RUN_W,
  parameter int unsigned SCNT_W    = CAN_STUFF_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sample_point,
  input  logic              rx,
  input  logic              stuff_en,
  input  logic              fixed_mode,
  input  logic              err_clear,
  output logic              bit_valid,
  output logic              bit_out,
  output logic              stuff_bit,
  output logic              stuff_err,
  output logic [SCNT_W-1:0] stuff_count
);

  localparam int unsigned       FIX_W    = $clog2(FIXED_LEN + 1);
  localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(RUN_LEN);
  localparam logic [FIX_W-1:0]  FIX_LOAD = FIX_W'(FIXED_LEN);

  logic [RUN_W-1:0]  run_cnt, run_cnt_n;
  logic [FIX_W-1:0]  fix_cnt, fix_cnt_n;
  logic              last_bit, last_bit_n;
  logic [SCNT_W-1:0] stuff_count_n;
  logic              bit_valid_n, bit_out_n, stuff_bit_n, stuff_err_n;
  logic              data_hit, stuff_hit, err_hit;

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_valid   <= 1'b0;
      bit_out     <= RECESSIVE;
      stuff_bit   <= 1'b0;
      stuff_err   <= 1'b0;
      stuff_count <= '0;
      run_cnt     <= '0;
      last_bit    <= RECESSIVE;
      fix_cnt     <= '0;
    end else begin
      bit_valid   <= bit_valid_n;
      bit_out     <= bit_out_n;
      stuff_bit   <= stuff_bit_n;
      stuff_err   <= stuff_err_n;
      stuff_count <= stuff_count_n;
      run_cnt     <= run_cnt_n;
      last_bit    <= last_bit_n;
      fix_cnt     <= fix_cnt_n;
    end
  end

  // Bit classification and next-state.
  always_comb begin
    run_cnt_n     = run_cnt;
    fix_cnt_n     = fixed_mode ? fix_cnt : '0;
    last_bit_n    = last_bit;
    stuff_count_n = stuff_count;
    bit_out_n     = bit_out;
    data_hit      = 1'b0;
    stuff_hit     = 1'b0;
    err_hit       = 1'b0;

    if (sample_point) begin
      unique case (stuff_mode(stuff_en, fixed_mode))
        STUFF_OFF: begin
          data_hit      = 1'b1;
          run_cnt_n     = '0;
          fix_cnt_n     = '0;
          stuff_count_n = '0;
        end
        STUFF_DYN: begin
          if (run_cnt == RUN_MAX) begin
            if (rx != last_bit) begin
              stuff_hit     = 1'b1;
              stuff_count_n = SCNT_W'(stuff_count + 1'b1);
              last_bit_n    = rx;
              run_cnt_n     = RUN_W'(1);
            end else begin
              err_hit = 1'b1;
            end
          end else begin
            data_hit   = 1'b1;
            run_cnt_n  = (run_cnt != '0 && rx == last_bit) ? RUN_W'(run_cnt + 1'b1)
                                                          : RUN_W'(1);
            last_bit_n = rx;
          end
        end
        STUFF_FIXED: begin
          last_bit_n = rx;
          if (fix_cnt == '0) begin
            stuff_hit = (rx != last_bit);
            err_hit   = (rx == last_bit);
            fix_cnt_n = FIX_LOAD;
          end else begin
            data_hit  = 1'b1;
            fix_cnt_n = FIX_W'(fix_cnt - 1'b1);
          end
        end
        default: ;
      endcase
    end

    // A pending error silences the decoder until it is cleared.
    bit_valid_n = data_hit & ~stuff_err;
    stuff_bit_n = stuff_hit & ~stuff_err;
    if (bit_valid_n) begin
      bit_out_n = rx;
    end
    stuff_err_n = err_hit | (stuff_err & ~err_clear);
  end

endmodule

// File: tb/tb_can_bit_destuffer.sv
// Directed bench for can_bit_destuffer with a queue of expected output sets.
module tb_can_bit_destuffer;

  logic       clock = 1'b0;
  logic       reset;
  logic       sample_point;
  logic       rx;
  logic       stuff_en;
  logic       fixed_mode;
  logic       err_clear;
  logic       bit_valid;
  logic       bit_out;
  logic       stuff_bit;
  logic       stuff_err;
  logic [2:0] stuff_count;

  typedef struct packed {
    logic       v;
    logic       bo;
    logic       st;
    logic       er;
    logic [2:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic exp_bo = 1'b1;

  always #5 clock = ~clock;

  can_bit_destuffer dut (
    .clock        (clock),
    .reset        (reset),
    .sample_point (sample_point),
    .rx           (rx),
    .stuff_en     (stuff_en),
    .fixed_mode   (fixed_mode),
    .err_clear    (err_clear),
    .bit_valid    (bit_valid),
    .bit_out      (bit_out),
    .stuff_bit    (stuff_bit),
    .stuff_err    (stuff_err),
    .stuff_count  (stuff_count)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic ev, input logic es, input logic ee, input logic [2:0] ec);
    exp_t e;
    e.v   = ev;
    e.bo  = exp_bo;
    e.st  = es;
    e.er  = ee;
    e.cnt = ec;
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 8'd1, 8'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_bit_valid"},   8'(bit_valid),   8'(e.v));
      chk({tag, "_bit_out"},     8'(bit_out),     8'(e.bo));
      chk({tag, "_stuff_bit"},   8'(stuff_bit),   8'(e.st));
      chk({tag, "_stuff_err"},   8'(stuff_err),   8'(e.er));
      chk({tag, "_stuff_count"}, 8'(stuff_count), 8'(e.cnt));
    end
  endtask

  // One sample point; outputs are checked after the capturing edge.
  task automatic sp(input string tag, input logic b, input logic ev, input logic es,
                    input logic ee, input logic [2:0] ec);
    @(negedge clock);
    rx           = b;
    sample_point = 1'b1;
    if (ev) exp_bo = b;
    push_exp(ev, es, ee, ec);
    @(negedge clock);
    sample_point = 1'b0;
    check_out(tag);
  endtask

  task automatic clear_err(input string tag, input logic [2:0] ec);
    @(negedge clock);
    err_clear = 1'b1;
    push_exp(1'b0, 1'b0, 1'b0, ec);
    @(negedge clock);
    err_clear = 1'b0;
    check_out(tag);
  endtask

  initial begin
    reset        = 1'b1;
    sample_point = 1'b0;
    rx           = 1'b1;
    stuff_en     = 1'b0;
    fixed_mode   = 1'b0;
    err_clear    = 1'b0;

    repeat (2) @(negedge clock);
    push_exp(1'b0, 1'b0, 1'b0, 3'd0);
    check_out("reset");
    reset = 1'b0;

    // Dynamic stuff after five dominant bits
    stuff_en = 1'b1;
    for (int i = 0; i < 5; i++) sp("dyn_data", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    sp("dyn_stuff", 1'b1, 1'b0, 1'b1, 1'b0, 3'd1);

    // Stuff error: six recessive bits from a fresh start
    stuff_en = 1'b0;
    sp("pass", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    stuff_en = 1'b1;
    for (int i = 0; i < 5; i++) sp("err_data", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    sp("err_set", 1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
    sp("err_quiet_stuff", 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
    sp("err_quiet_data", 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
    clear_err("err_clear", 3'd1);
    stuff_en = 1'b0;
    sp("abort", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);

    // Run restarts on polarity change; the bit after five ones is stuff
    stuff_en = 1'b1;
    for (int i = 0; i < 4; i++) sp("run_zero", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 5; i++) sp("run_one", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    sp("run_stuff", 1'b0, 1'b0, 1'b1, 1'b0, 3'd1);
    stuff_en = 1'b0;
    sp("run_abort", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);

    // stuff_count wraps modulo 8
    stuff_en = 1'b1;
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < 5; i++) sp("wrap_data", 1'b0, 1'b1, 1'b0, 1'b0, 3'(k % 8));
      sp("wrap_stuff", 1'b1, 1'b0, 1'b1, 1'b0, 3'((k + 1) % 8));
    end
    stuff_en = 1'b0;
    sp("wrap_clear", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);

    // Fixed stuffing with last_bit dominant on entry
    stuff_en = 1'b1;
    sp("fix_pre", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    fixed_mode = 1'b1;
    sp("fix_stuff1", 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    sp("fix_a", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    sp("fix_b", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    sp("fix_c", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    sp("fix_d", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    sp("fix_stuff2", 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    sp("fix_a2", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    sp("fix_b2", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    sp("fix_c2", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    sp("fix_d2", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    sp("fix_err", 1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
    clear_err("fix_clear", 3'd0);
    fixed_mode = 1'b0;
    stuff_en   = 1'b0;
    sp("fix_exit", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);

    // Asynchronous reset mid-frame
    stuff_en = 1'b1;
    for (int i = 0; i < 3; i++) sp("pre_rst", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    exp_bo = 1'b1;
    push_exp(1'b0, 1'b0, 1'b0, 3'd0);
    check_out("mid_reset");
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) sp("post_rst_data", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    sp("post_rst_stuff", 1'b1, 1'b0, 1'b1, 1'b0, 3'd1);

    chk("sb_drained", 8'(sb.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
